uart_fifo_level_mon: RTL and testbench
======================================

# uart_fifo_level_mon

Level monitor that sits directly downstream of the UART RX FIFO pointer/counter logic and consumes its depth, full and empty status together with the FIFO push/pop strobes. It produces registered watermark status, one-cycle interrupt events for watermark crossing, overflow and RX character timeout, plus an integrity error flag. Its outputs feed the UART interrupt/status register block.

## Interface
- Depth, 32: FIFO capacity in entries; must match the monitored FIFO.
- TimeoutW, 8: width of timeout threshold and character-time counter.
- DepthW, vbits(Depth+1) (derived localparam, not overridable): width of depth/level values.

- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- clr_i  in  1  synchronous clear, same cycle as FIFO clear; acts like reset on all state except sticky ovf_o
- depth_i  in  DepthW  current FIFO entry count, range 0..Depth
- full_i  in  1  FIFO full
- empty_i  in  1  FIFO empty
- push_i  in  1  write attempt toward FIFO this cycle
- pop_i  in  1  read accepted from FIFO this cycle
- wm_lvl_i  in  DepthW  watermark threshold; 0 disables watermark
- char_tick_i  in  1  one-cycle pulse per character time from baud generator
- timeout_val_i  in  TimeoutW  timeout in character times; 0 disables timeout
- ovf_clr_i  in  1  clears sticky overflow
- wm_o  out  1  registered: depth >= threshold
- wm_event_o  out  1  one-cycle pulse on wm_o rising
- ovf_o  out  1  sticky overflow flag
- ovf_event_o  out  1  one-cycle pulse per dropped write
- timeout_event_o  out  1  one-cycle pulse when idle timeout expires
- err_o  out  1  registered status-consistency error

## Operation
- Reset (rst_i): all outputs 0, counter 0, FSM IDLE. rst_i has priority over clr_i and all inputs.
- Watermark: wm_next = (wm_lvl_i != 0) && (depth_i >= wm_lvl_i), unsigned DepthW compare. wm_o <= wm_next. wm_event_o <= wm_next & ~wm_o. Threshold above Depth never asserts.
- Overflow: drop = push_i & full_i (write dropped regardless of pop_i). ovf_event_o <= drop. ovf_o set by drop, cleared by ovf_clr_i; drop wins over ovf_clr_i in the same cycle. clr_i does not clear ovf_o.
- Integrity: err_next = (depth_i > Depth) | (empty_i != (depth_i == 0)) | (full_i != (depth_i == Depth)). err_o <= err_next (not sticky).
- Timeout FSM, activity = push_i | pop_i:
  - IDLE: counter 0. Go COUNT when ~empty_i and timeout_val_i != 0.
  - COUNT: activity -> counter 0, stay. char_tick_i without activity -> counter+1; if counter+1 == timeout_val_i, pulse timeout_event_o, go EXPIRED. empty_i or timeout_val_i == 0 -> IDLE, counter 0.
  - EXPIRED: no further events. activity -> COUNT, counter 0 (or IDLE if empty_i). empty_i -> IDLE.
  - Counter saturates at all-ones; never wraps.
- clr_i: FSM IDLE, counter 0, wm_o/wm_event_o/ovf_event_o/timeout_event_o/err_o 0 next cycle.

## Timing
- All outputs registered; 1-cycle latency from the sampled inputs.
- depth_i/full_i/empty_i are the pre-update state of the same cycle as push_i/pop_i; no lookahead.
- Events are single-cycle pulses; a continuously satisfied condition gives exactly one wm_event_o.
- Simultaneous activity and char_tick_i in COUNT: activity wins, counter 0, no event.
- timeout_val_i changed mid-count: compared against the live value; if the counter already exceeds it no event fires until activity restarts counting.
- Simultaneous drop and ovf_clr_i: ovf_o = 1 next cycle.

## Test plan
- Reset: assert rst_i with depth_i=5, push_i=1, full_i=1 -> all outputs 0 next cycle and while held.
- Watermark: wm_lvl_i=4; depth_i 3->4->5->4->3 -> wm_o 0,1,1,1,0 one cycle later; wm_event_o pulses once, on the 3->4 step only.
- Overflow: depth_i=32, full_i=1, push_i=1 for 2 cycles -> ovf_event_o pulses 2 cycles, ovf_o stays 1; ovf_clr_i with push_i -> ovf_o stays 1; ovf_clr_i alone -> 0.
- Timeout: depth_i=1, timeout_val_i=3, ticks every 10 cycles, no activity -> timeout_event_o single pulse one cycle after 3rd tick, none after 4th; a pop_i -> restart, pulse again after 3 more ticks.
- Tick/activity collision: push_i with char_tick_i every tick -> no timeout_event_o ever; clr_i mid-count -> IDLE, counter 0.
- Integrity: depth_i=0 with empty_i=0 -> err_o=1 next cycle; depth_i=33 -> err_o=1; consistent inputs -> err_o=0.

Source files
------------

// File: rtl/uart_fifo_level_mon.sv
// uart_fifo_level_mon
//   Watches the UART RX FIFO status and strobes and produces registered
//   watermark, overflow, RX character-timeout and integrity status for the
//   interrupt/status register block.
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   clr_i               FIFO clear; resets everything except sticky ovf_o
//   depth_i/full_i/empty_i  FIFO status (pre-update state of this cycle)
//   push_i/pop_i        FIFO write attempt / accepted read this cycle
//   wm_lvl_i            watermark threshold, 0 disables
//   char_tick_i         one pulse per character time
//   timeout_val_i       idle timeout in character times, 0 disables
//   ovf_clr_i           clears sticky overflow
//   wm_o, wm_event_o    watermark level and its rising-edge pulse
//   ovf_o, ovf_event_o  sticky overflow and per-drop pulse
//   timeout_event_o     idle timeout pulse
//   err_o               status-consistency error
module uart_fifo_level_mon #(
  parameter  int Depth    = 32,
  parameter  int TimeoutW = 8,
  localparam int DepthW   = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [DepthW-1:0]   depth_i,
  input  logic                full_i,
  input  logic                empty_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [DepthW-1:0]   wm_lvl_i,
  input  logic                char_tick_i,
  input  logic [TimeoutW-1:0] timeout_val_i,
  input  logic                ovf_clr_i,
  output logic                wm_o,
  output logic                wm_event_o,
  output logic                ovf_o,
  output logic                ovf_event_o,
  output logic                timeout_event_o,
  output logic                err_o
);

  localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_e;

  state_e              state_q, state_d;
  logic [TimeoutW-1:0] cnt_q, cnt_d, cnt_inc;
  logic                wm_q, wm_d, wm_event_q, wm_event_d;
  logic                ovf_q, ovf_d, ovf_event_q, ovf_event_d;
  logic                tmo_event_q, tmo_event_d;
  logic                err_q, err_d;
  logic                activity, drop;

  assign activity = push_i | pop_i;
  assign drop     = push_i & full_i;

  // Status datapath
  always_comb begin
    wm_d        = (wm_lvl_i != '0) && (depth_i >= wm_lvl_i);
    wm_event_d  = wm_d & ~wm_q;
    ovf_event_d = drop;
    // a drop in the same cycle as the clear keeps the flag set
    ovf_d       = drop | (ovf_q & ~ovf_clr_i);
    err_d       = (depth_i > DepthMax) | (empty_i != (depth_i == '0)) |
                  (full_i != (depth_i == DepthMax));
  end

  // Timeout FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // counter saturates rather than wrapping
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TimeoutW'(1);

  // Timeout FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!empty_i && timeout_val_i != '0) state_d = COUNT;
      end
      COUNT: begin
        if (empty_i || timeout_val_i == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (activity) begin
          cnt_d = '0;   // activity beats a coincident tick
        end else if (char_tick_i) begin
          cnt_d = cnt_inc;
          // equality against the live value: a counter already past a
          // lowered threshold stays silent until activity restarts it
          if (cnt_q != '1 && cnt_inc == timeout_val_i) state_d = EXPIRED;
        end
      end
      EXPIRED: begin
        if (empty_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (activity) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Timeout FSM: output (event fires on the COUNT->EXPIRED transition)
  always_comb begin
    tmo_event_d = (state_q == COUNT) && (state_d == EXPIRED);
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wm_q        <= 1'b0;
      wm_event_q  <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_event_q <= 1'b0;
      tmo_event_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (clr_i) begin
      wm_q        <= 1'b0;
      wm_event_q  <= 1'b0;
      ovf_q       <= ovf_d;
      ovf_event_q <= 1'b0;
      tmo_event_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wm_q        <= wm_d;
      wm_event_q  <= wm_event_d;
      ovf_q       <= ovf_d;
      ovf_event_q <= ovf_event_d;
      tmo_event_q <= tmo_event_d;
      err_q       <= err_d;
    end
  end

  assign wm_o            = wm_q;
  assign wm_event_o      = wm_event_q;
  assign ovf_o           = ovf_q;
  assign ovf_event_o     = ovf_event_q;
  assign timeout_event_o = tmo_event_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_uart_fifo_level_mon.sv
// Directed bench for uart_fifo_level_mon. Inputs change 1 time unit after a
// rising edge; outputs are sampled 1 unit after the next edge.
module tb_uart_fifo_level_mon;
  localparam int DepthW = 6;

  logic              clk_i = 1'b0;
  logic              rst_i, clr_i, full_i, empty_i, push_i, pop_i;
  logic              char_tick_i, ovf_clr_i;
  logic [DepthW-1:0] depth_i, wm_lvl_i;
  logic [7:0]        timeout_val_i;
  logic              wm_o, wm_event_o, ovf_o, ovf_event_o, timeout_event_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  uart_fifo_level_mon dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .depth_i(depth_i),
    .full_i(full_i), .empty_i(empty_i), .push_i(push_i), .pop_i(pop_i),
    .wm_lvl_i(wm_lvl_i), .char_tick_i(char_tick_i),
    .timeout_val_i(timeout_val_i), .ovf_clr_i(ovf_clr_i),
    .wm_o(wm_o), .wm_event_o(wm_event_o), .ovf_o(ovf_o),
    .ovf_event_o(ovf_event_o), .timeout_event_o(timeout_event_o),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic set_depth(input int d);
    depth_i = DepthW'(d);
    empty_i = (d == 0);
    full_i  = (d == 32);
  endtask

  // n character ticks spaced 10 cycles apart; timeout pulse expected only
  // right after tick number fire_at (0 = never)
  task automatic run_ticks(input string tag, input int n, input int fire_at);
    for (int k = 1; k <= n; k++) begin
      for (int c = 0; c < 9; c++) begin
        step();
        chk({tag, "_quiet"}, timeout_event_o, 0);
      end
      char_tick_i = 1'b1;
      step();
      chk({tag, "_tick"}, timeout_event_o, (k == fire_at) ? 1 : 0);
      char_tick_i = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; push_i = 1'b1; pop_i = 1'b0;
    depth_i = 6'd5; full_i = 1'b1; empty_i = 1'b0;
    wm_lvl_i = '0; char_tick_i = 1'b0; timeout_val_i = '0; ovf_clr_i = 1'b0;

    // reset dominates inconsistent/dropping inputs
    step();
    chk("rst_outs", {wm_o, wm_event_o, ovf_o, ovf_event_o, timeout_event_o, err_o}, 0);
    step();
    chk("rst_held", {wm_o, wm_event_o, ovf_o, ovf_event_o, timeout_event_o, err_o}, 0);
    rst_i = 1'b0; push_i = 1'b0; set_depth(0);
    step();
    chk("post_rst", {wm_o, wm_event_o, ovf_o, ovf_event_o, timeout_event_o, err_o}, 0);

    // watermark 3->4->5->4->3 at threshold 4
    begin
      int dv[5]  = '{3, 4, 5, 4, 3};
      int wm[5]  = '{0, 1, 1, 1, 0};
      int ev[5]  = '{0, 1, 0, 0, 0};
      wm_lvl_i = 6'd4;
      for (int i = 0; i < 5; i++) begin
        set_depth(dv[i]);
        step();
        chk("wm_lvl", wm_o, wm[i]);
        chk("wm_ev", wm_event_o, ev[i]);
      end
    end
    wm_lvl_i = 6'd32; set_depth(32);
    step();
    chk("wm_eq_depth", wm_o, 1);
    chk("wm_eq_depth_ev", wm_event_o, 1);
    wm_lvl_i = 6'd40;
    step();
    chk("wm_above_depth", wm_o, 0);
    wm_lvl_i = 6'd0;
    step();
    chk("wm_disabled", wm_o, 0);

    // overflow
    push_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ovf_ev", ovf_event_o, 1);
      chk("ovf_sticky", ovf_o, 1);
    end
    push_i = 1'b0;
    step();
    chk("ovf_ev_end", ovf_event_o, 0);
    chk("ovf_hold", ovf_o, 1);
    push_i = 1'b1; ovf_clr_i = 1'b1;
    step();
    chk("ovf_drop_wins", ovf_o, 1);
    push_i = 1'b0;
    step();
    chk("ovf_cleared", ovf_o, 0);
    ovf_clr_i = 1'b0; push_i = 1'b1;
    step();
    chk("ovf_set_again", ovf_o, 1);
    push_i = 1'b0; clr_i = 1'b1;
    step();
    chk("ovf_survives_clr", ovf_o, 1);
    chk("clr_ovf_ev", ovf_event_o, 0);
    clr_i = 1'b0; ovf_clr_i = 1'b1;
    step();
    chk("ovf_clr2", ovf_o, 0);
    ovf_clr_i = 1'b0;

    // timeout: 3 character times
    set_depth(1); timeout_val_i = 8'd3;
    run_ticks("tmo_first", 4, 3);
    pop_i = 1'b1;
    step();
    chk("tmo_pop", timeout_event_o, 0);
    pop_i = 1'b0;
    run_ticks("tmo_restart", 3, 3);

    // activity colliding with every tick never times out
    push_i = 1'b1;
    run_ticks("tmo_collide", 5, 0);
    push_i = 1'b0;
    run_ticks("tmo_partial", 2, 0);
    clr_i = 1'b1;
    step();
    chk("clr_outs", {wm_o, wm_event_o, ovf_event_o, timeout_event_o, err_o}, 0);
    clr_i = 1'b0;
    run_ticks("tmo_after_clr", 3, 3);

    // threshold lowered below a running count: silent
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    run_ticks("tmo_pre_lower", 2, 0);
    timeout_val_i = 8'd1;
    run_ticks("tmo_lowered", 3, 0);
    timeout_val_i = 8'd0;

    // integrity
    depth_i = 6'd0; empty_i = 1'b0; full_i = 1'b0;
    step();
    chk("err_empty", err_o, 1);
    depth_i = 6'd33;
    step();
    chk("err_over", err_o, 1);
    set_depth(10);
    step();
    chk("err_ok_mid", err_o, 0);
    depth_i = 6'd32; full_i = 1'b0;
    step();
    chk("err_full", err_o, 1);
    set_depth(0);
    step();
    chk("err_ok_empty", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
